// File: rtl/bw_io_jp_tap_pkg.sv
// Shared TAP definitions: state encoding, IR opcodes, ID constant, instruction decode.
// Build option: BW_IO_JP_TAP_IDCODE_EN adds the IDCODE register and makes it the reset instruction.
package bw_io_jp_tap_pkg;

  // IEEE 1149.1 recommended state encoding
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tapState_e;

  typedef enum logic [2:0] {
    I_EXTEST,
    I_SAMPLE,
    I_IDCODE,
    I_HIGHZ,
    I_CLAMP,
    I_BYPASS
  } instr_e;

  localparam int              IR_W       = 4;
  localparam logic [IR_W-1:0] IR_EXTEST  = 4'h0;
  localparam logic [IR_W-1:0] IR_SAMPLE  = 4'h1;
  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h2;
  localparam logic [IR_W-1:0] IR_HIGHZ   = 4'h3;
  localparam logic [IR_W-1:0] IR_CLAMP   = 4'h4;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;
  localparam logic [31:0]     ID_CODE    = 32'h1000_003F;

`ifdef BW_IO_JP_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_BYPASS;
`endif

  // Unlisted opcodes (and IDCODE when the register is absent) fall back to BYPASS
  function automatic instr_e decodeIr(input logic [IR_W-1:0] ir);
    instr_e res;
    case (ir)
      IR_EXTEST: res = I_EXTEST;
      IR_SAMPLE: res = I_SAMPLE;
`ifdef BW_IO_JP_TAP_IDCODE_EN
      IR_IDCODE: res = I_IDCODE;
`endif
      IR_HIGHZ:  res = I_HIGHZ;
      IR_CLAMP:  res = I_CLAMP;
      default:   res = I_BYPASS;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bw_io_jp_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; advances on every tck rising edge.
module bw_io_jp_tap_fsm
  import bw_io_jp_tap_pkg::*;
(
  input  logic      tck,
  input  logic      trst_l,
  input  logic      tms,
  output tapState_e state
);

  tapState_e r_state;

  always_ff @(posedge tck) begin
    if (!trst_l) begin
      r_state <= TLR;
    end else begin
      case (r_state)
        TLR:     r_state <= tms ? TLR    : RTI;
        RTI:     r_state <= tms ? SEL_DR : RTI;
        SEL_DR:  r_state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:  r_state <= tms ? EX1_DR : SH_DR;
        SH_DR:   r_state <= tms ? EX1_DR : SH_DR;
        EX1_DR:  r_state <= tms ? UPD_DR : PAU_DR;
        PAU_DR:  r_state <= tms ? EX2_DR : PAU_DR;
        EX2_DR:  r_state <= tms ? UPD_DR : SH_DR;
        UPD_DR:  r_state <= tms ? SEL_DR : RTI;
        SEL_IR:  r_state <= tms ? TLR    : CAP_IR;
        CAP_IR:  r_state <= tms ? EX1_IR : SH_IR;
        SH_IR:   r_state <= tms ? EX1_IR : SH_IR;
        EX1_IR:  r_state <= tms ? UPD_IR : PAU_IR;
        PAU_IR:  r_state <= tms ? EX2_IR : PAU_IR;
        EX2_IR:  r_state <= tms ? UPD_IR : SH_IR;
        UPD_IR:  r_state <= tms ? SEL_DR : RTI;
        default: r_state <= TLR;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: rtl/bw_io_jp_tap_bsctl.sv
// JTAG boundary-scan controller: IR, bypass/IDCODE registers, BSR strobes and pad mode control.
// Build option: BW_IO_JP_TAP_IDCODE_EN includes the 32-bit IDCODE register.
module bw_io_jp_tap_bsctl
  import bw_io_jp_tap_pkg::*;
(
  input  logic tck,
  input  logic trst_l,
  input  logic tms,
  input  logic tdi,
  input  logic bsr_so,
  output logic bsr_si,
  output logic shift_dr,
  output logic clock_dr,
  output logic update_dr,
  output logic mode_ctl,
  output logic bsr_hiz_l,
  output logic tdo,
  output logic tdo_en
);

  tapState_e       w_state;
  logic [IR_W-1:0] r_irShift;
  logic [IR_W-1:0] r_irQ;
  logic [IR_W-1:0] w_irQNext;
  instr_e          w_instr;
  instr_e          w_instrNext;
  logic            w_bsrSel;
  logic            w_drLsb;
  logic            r_bypass;
  logic            r_tdo;
  logic            r_tdoEn;
  logic            r_modeCtl;
  logic            r_bsrHizL;

  bw_io_jp_tap_fsm u_fsm (
    .tck    (tck),
    .trst_l (trst_l),
    .tms    (tms),
    .state  (w_state)
  );

  assign w_instr  = decodeIr(r_irQ);
  assign w_bsrSel = (w_instr == I_EXTEST) || (w_instr == I_SAMPLE);

  // TLR continuously re-asserts the reset instruction; UPD_IR commits the shifted opcode
  always_comb begin
    w_irQNext = r_irQ;
    if (w_state == TLR) begin
      w_irQNext = IR_RESET;
    end else if (w_state == UPD_IR) begin
      w_irQNext = r_irShift;
    end
  end

  assign w_instrNext = decodeIr(w_irQNext);

  always_ff @(posedge tck) begin
    if (!trst_l) begin
      r_irShift <= IR_CAPTURE;
      r_irQ     <= IR_RESET;
      r_modeCtl <= 1'b0;
      r_bsrHizL <= 1'b1;
    end else begin
      if (w_state == CAP_IR) begin
        r_irShift <= IR_CAPTURE;
      end else if (w_state == SH_IR) begin
        r_irShift <= {tdi, r_irShift[IR_W-1:1]};
      end
      r_irQ     <= w_irQNext;
      r_modeCtl <= (w_instrNext == I_EXTEST) || (w_instrNext == I_CLAMP);
      r_bsrHizL <= (w_instrNext != I_HIGHZ);
    end
  end

  always_ff @(posedge tck) begin
    if (!trst_l) begin
      r_bypass <= 1'b0;
    end else if (w_state == CAP_DR) begin
      r_bypass <= 1'b0;
    end else if (w_state == SH_DR) begin
      r_bypass <= tdi;
    end
  end

`ifdef BW_IO_JP_TAP_IDCODE_EN
  logic [31:0] r_idcode;

  always_ff @(posedge tck) begin
    if (!trst_l) begin
      r_idcode <= ID_CODE;
    end else if (w_state == CAP_DR) begin
      r_idcode <= ID_CODE;
    end else if (w_state == SH_DR) begin
      r_idcode <= {tdi, r_idcode[31:1]};
    end
  end

  always_comb begin
    w_drLsb = r_bypass;
    if (w_bsrSel) begin
      w_drLsb = bsr_so;
    end else if (w_instr == I_IDCODE) begin
      w_drLsb = r_idcode[0];
    end
  end
`else
  always_comb begin
    w_drLsb = r_bypass;
    if (w_bsrSel) begin
      w_drLsb = bsr_so;
    end
  end
`endif

  always_ff @(posedge tck) begin
    if (!trst_l) begin
      r_tdo   <= 1'b0;
      r_tdoEn <= 1'b0;
    end else begin
      r_tdoEn <= (w_state == SH_IR) || (w_state == SH_DR);
      if (w_state == SH_IR) begin
        r_tdo <= r_irShift[0];
      end else if (w_state == SH_DR) begin
        r_tdo <= w_drLsb;
      end
    end
  end

  // Strobes are qualified by trst_l so an asserted reset suppresses them within the same cycle
  assign shift_dr  = trst_l & w_bsrSel & (w_state == SH_DR);
  assign clock_dr  = trst_l & w_bsrSel & ((w_state == CAP_DR) || (w_state == SH_DR));
  assign update_dr = trst_l & w_bsrSel & (w_state == UPD_DR);

  assign bsr_si    = tdi;
  assign mode_ctl  = r_modeCtl;
  assign bsr_hiz_l = r_bsrHizL;
  assign tdo       = r_tdo;
  assign tdo_en    = r_tdoEn;

endmodule

// File: tb/tb_bw_io_jp_tap_bsctl.sv
// Scoreboard bench for bw_io_jp_tap_bsctl with an 8-cell boundary-scan chain model.
// Honours BW_IO_JP_TAP_IDCODE_EN for the reset instruction and IDCODE path.
`timescale 1ns/1ps
module tb_bw_io_jp_tap_bsctl;

  localparam logic [31:0] ID_VALUE    = 32'h1000_003F;
  localparam logic [7:0]  PAD_CAPTURE = 8'h3C;
`ifdef BW_IO_JP_TAP_IDCODE_EN
  localparam logic [3:0]  RESET_IR    = 4'h2;
`else
  localparam logic [3:0]  RESET_IR    = 4'hF;
`endif

  typedef enum int {P_BSR, P_IDCODE, P_BYPASS} path_e;

  logic tck    = 1'b0;
  logic trst_l = 1'b0;
  logic tms    = 1'b1;
  logic tdi    = 1'b0;
  logic bsr_so, bsr_si, shift_dr, clock_dr, update_dr, mode_ctl, bsr_hiz_l, tdo, tdo_en;

  int checks   = 0;
  int failures = 0;
  int clkDrCnt = 0;
  int shDrCnt  = 0;
  int updCnt   = 0;

  logic expQ[$];
  logic pathQ[$];
  logic expBit;
  logic [3:0] irModel = RESET_IR;

  logic [7:0] chain    = '0;
  logic [7:0] updLatch = '0;
  logic [7:0] expLatch = '0;

  always #5 tck = ~tck;

  bw_io_jp_tap_bsctl dut (
    .tck       (tck),
    .trst_l    (trst_l),
    .tms       (tms),
    .tdi       (tdi),
    .bsr_so    (bsr_so),
    .bsr_si    (bsr_si),
    .shift_dr  (shift_dr),
    .clock_dr  (clock_dr),
    .update_dr (update_dr),
    .mode_ctl  (mode_ctl),
    .bsr_hiz_l (bsr_hiz_l),
    .tdo       (tdo),
    .tdo_en    (tdo_en)
  );

  // External boundary-scan chain: captures pad values, shifts toward bsr_so, latches on update
  assign bsr_so = chain[0];
  always @(posedge tck) begin
    if (clock_dr) chain <= shift_dr ? {bsr_si, chain[7:1]} : PAD_CAPTURE;
    if (update_dr) updLatch <= chain;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic path_e pathOf(input logic [3:0] ir);
    if (ir == 4'h0 || ir == 4'h1) return P_BSR;
`ifdef BW_IO_JP_TAP_IDCODE_EN
    if (ir == 4'h2) return P_IDCODE;
`endif
    return P_BYPASS;
  endfunction

  function automatic logic [63:0] packPath();
    logic [63:0] v;
    v = '0;
    foreach (pathQ[i]) v[i] = pathQ[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #2;
  endtask

  task automatic loadPath(input int len, input logic [31:0] cap);
    pathQ.delete();
    for (int i = 0; i < len; i++) pathQ.push_back(cap[i]);
  endtask

  task automatic loadDrPath(input path_e p);
    case (p)
      P_BSR:    loadPath(8, {24'h0, PAD_CAPTURE});
      P_IDCODE: loadPath(32, ID_VALUE);
      default:  loadPath(1, 32'h0);
    endcase
  endtask

  // A serial path delivers its captured bits first, then whatever was shifted in
  task automatic shiftBit(input logic m, input logic d);
    expQ.push_back(pathQ.pop_front());
    pathQ.push_back(d);
    tick(m, d);
  endtask

  task automatic checkPads(input string tag);
    checkOutput({tag, "_mode_ctl"}, 32'(mode_ctl), 32'(irModel == 4'h0 || irModel == 4'h4));
    checkOutput({tag, "_bsr_hiz_l"}, 32'(bsr_hiz_l), 32'(irModel != 4'h3));
    checkOutput({tag, "_sb_drain"}, 32'(expQ.size()), 32'h0);
  endtask

  task automatic scanIR(input int n, input logic [63:0] bits, input bit rstInUpd, input string tag);
    logic [63:0] content;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    loadPath(4, 32'h1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) shiftBit(i == n - 1, bits[i]);
    tick(1'b1, 1'b0);
    content = packPath();
    if (rstInUpd) begin
      trst_l = 1'b0;
      tick(1'b0, 1'b0);
      trst_l = 1'b1;
      irModel = RESET_IR;
    end else begin
      irModel = content[3:0];
    end
    tick(1'b0, 1'b0);
    checkPads(tag);
  endtask

  task automatic scanDR(input int n, input logic [63:0] bits, input bit rstInUpd, input string tag);
    int c0, s0, u0;
    path_e p;
    logic [63:0] content;
    c0 = clkDrCnt;
    s0 = shDrCnt;
    u0 = updCnt;
    p  = pathOf(irModel);
    tick(1'b1, 1'b0);
    loadDrPath(p);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) shiftBit(i == n - 1, bits[i]);
    tick(1'b1, 1'b0);
    content = packPath();
    if (rstInUpd) begin
      trst_l = 1'b0;
      tick(1'b0, 1'b0);
      trst_l = 1'b1;
      irModel = RESET_IR;
    end else if (p == P_BSR) begin
      expLatch = content[7:0];
    end
    tick(1'b0, 1'b0);
    checkOutput({tag, "_clock_dr_cycles"}, 32'(clkDrCnt - c0), (p == P_BSR) ? 32'(n + 1) : 32'h0);
    checkOutput({tag, "_shift_dr_cycles"}, 32'(shDrCnt - s0), (p == P_BSR) ? 32'(n) : 32'h0);
    checkOutput({tag, "_update_dr_pulses"}, 32'(updCnt - u0), (p == P_BSR && !rstInUpd) ? 32'h1 : 32'h0);
    checkOutput({tag, "_update_latch"}, 32'(updLatch), 32'(expLatch));
    checkPads(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_shift_dr"}, 32'(shift_dr), 32'h0);
    checkOutput({tag, "_clock_dr"}, 32'(clock_dr), 32'h0);
    checkOutput({tag, "_update_dr"}, 32'(update_dr), 32'h0);
    checkOutput({tag, "_mode_ctl"}, 32'(mode_ctl), 32'h0);
    checkOutput({tag, "_bsr_hiz_l"}, 32'(bsr_hiz_l), 32'h1);
    checkOutput({tag, "_tdo_en"}, 32'(tdo_en), 32'h0);
    checkOutput({tag, "_tdo"}, 32'(tdo), 32'h0);
  endtask

  task automatic resetMidShift(input int k);
    tick(1'b1, 1'b0);
    loadDrPath(pathOf(irModel));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < k; i++) shiftBit(1'b0, 1'($urandom_range(0, 1)));
    trst_l = 1'b0;
    #1;
    checkOutput("rst_during_shift_dr", 32'(shift_dr), 32'h0);
    checkOutput("rst_during_clock_dr", 32'(clock_dr), 32'h0);
    tick(1'b0, 1'b0);
    trst_l = 1'b1;
    irModel = RESET_IR;
    checkResetOutputs("rst_mid_shift");
    tick(1'b0, 1'b0);
    checkPads("rst_mid_shift_rti");
  endtask

  task automatic tlrRecovery();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    loadPath(4, 32'h1);
    tick(1'b0, 1'b0);
    shiftBit(1'b0, 1'($urandom_range(0, 1)));
    shiftBit(1'b1, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    irModel = RESET_IR;
    checkPads("tlr_recovery");
  endtask

  task automatic applyStimulus(input int iter);
    int nIr, nDr;
    logic [63:0] bits;
    nIr  = 4 + $urandom_range(0, 2);
    bits = {$urandom, $urandom};
    if ($urandom_range(0, 2) == 0) bits[nIr-4 +: 4] = 4'($urandom_range(0, 1));
    scanIR(nIr, bits, $urandom_range(0, 11) == 0, $sformatf("rnd%0d_ir", iter));
    nDr  = $urandom_range(1, 40);
    bits = {$urandom, $urandom};
    scanDR(nDr, bits, $urandom_range(0, 9) == 0, $sformatf("rnd%0d_dr", iter));
  endtask

  initial begin
    fork
      forever begin
        @(negedge tck);
        if (clock_dr === 1'b1) clkDrCnt++;
        if (shift_dr === 1'b1) shDrCnt++;
        if (update_dr === 1'b1) updCnt++;
        if (tdo_en === 1'b1) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL tdo_spurious: got tdo_en=1 tdo=%b, required no output", tdo);
          end else begin
            expBit = expQ.pop_front();
            checkOutput("tdo", 32'(tdo), 32'(expBit));
          end
        end
      end
    join_none

    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checkResetOutputs("por");
    trst_l = 1'b1;
    tick(1'b0, 1'b0);

    scanDR(32, {$urandom, $urandom}, 1'b0, "idcode");

    scanIR(4, 64'hF, 1'b0, "bypass_ir");
    scanDR(4, 64'hD, 1'b0, "bypass_dr");

    scanIR(4, 64'h3, 1'b0, "highz_ir");
    scanDR(6, {$urandom, $urandom}, 1'b0, "highz_dr");

    scanIR(4, 64'h0, 1'b0, "extest_ir");
    scanDR(8, 64'hA5, 1'b0, "extest_dr");

    resetMidShift(3);

    scanIR(4, 64'h0, 1'b0, "extest2_ir");
    scanDR(8, {$urandom, $urandom}, 1'b1, "extest_rst_upd");

    scanIR(4, 64'h3, 1'b1, "highz_rst_upd");

    scanIR(4, 64'h4, 1'b0, "clamp_ir");
    tlrRecovery();
    scanDR(5, {$urandom, $urandom}, 1'b0, "after_tlr_dr");

    for (int i = 0; i < 30; i++) applyStimulus(i);

    checkOutput("final_sb_drain", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
